tdm_demux1x4: RTL and testbench
===============================

# tdm_demux1x4

Time-division demultiplexer that receives one sample stream and distributes consecutive samples across four parallel lanes. It is the receive end of a 4:1 time-slot multiplexed link. A frame-sync marker aligns slot 0. Once all four slots of a frame are captured, the block presents them as one registered word with a valid/ready handshake.

## Interface
- WIDTH, 1, bits per sample/lane
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  incoming sample
- in_valid  input  1  sample present this cycle
- in_sync  input  1  qualified by in_valid; marks the sample as slot 0 of a frame
- out_data  output  4*WIDTH  lane3..lane0 packed, lane0 in LSBs
- out_valid  output  1  frame word available
- out_ready  input  1  consumer accepts out_data
- locked  output  1  high while frame-aligned
- sync_err  output  1  one-cycle pulse on an unexpected sync
- overflow  output  1  one-cycle pulse when an unaccepted frame is overwritten

## Operation
- Reset values:
  - State HUNT; slot counter 0; lane registers 0.
  - out_data 0; out_valid 0; locked 0; sync_err 0; overflow 0.
- States:
  - HUNT: samples are discarded until in_valid and in_sync are both high. That sample is written to lane0, slot becomes 1, and the state moves to LOCKED.
  - LOCKED: each in_valid sample is written to lane[slot], then slot increments. The 2-bit counter wraps 3→0.
- Frame completion: the write to slot 3 copies {sample, lane2, lane1, lane0} into out_data and sets out_valid.
- Sync check in LOCKED:
  - in_sync with slot 0 is a normal frame start.
  - in_sync with slot≠0 pulses sync_err and discards the partial frame. The sample is written to lane0, slot becomes 1, and the block stays LOCKED.
  - in_valid with slot 0 and no in_sync pulses sync_err, drops the sample, and returns to HUNT.
- Output handshake:
  - out_valid stays high until a cycle with out_valid && out_ready; it clears on the next edge.
  - If a frame completes in the same cycle as acceptance, out_valid stays high and out_data takes the new frame.
  - If a frame completes while out_valid is high and out_ready is low, out_data is overwritten and overflow pulses. out_valid remains high.
- Backpressure: none on the input; in_valid can never be stalled.
- locked equals (state == LOCKED).
- Lane registers not yet written in the current frame hold stale values. They are never visible because out_data is only loaded on a slot-3 write.

## Timing
- Latency: a slot-3 sample accepted at edge t produces out_valid/out_data visible after edge t, i.e. in cycle t+1.
- sync_err and overflow are registered. They are high for exactly the one cycle following the offending edge.
- in_valid low leaves slot, state and lanes unchanged. Gaps of any length are legal.
- Reset asserted mid-frame clears all state immediately (asynchronous). The first edge after deassertion is in HUNT.
- An in_sync in HUNT on the same edge the first sample arrives gives locked=1 in the following cycle.

## Structure
- Shared package tdm_pkg:
  - slot_t (2-bit slot index).
  - state_t enum {HUNT, LOCKED}.
  - NUM_LANES = 4.
- Sub-module demux_dec2to4: combinational decoder from slot and write enable to a 4-bit one-hot lane write-enable. It is instantiated once and drives the lane register enables.
- The top level holds the FSM, slot counter, lane registers, output register and handshake logic.

## Test plan
- Aligned frames (WIDTH=8): sync+0x11, then 0x22, 0x33, 0x44 with out_ready=1 → out_data=0x44332211, out_valid for 1 cycle, locked=1.
- HUNT discard: 0xAA, 0xBB without sync, then an aligned frame 1,2,3,4 → only 0x04030201 is output; locked rises after the sync sample.
- Misplaced sync: sync+1, 2, then sync+5, 6, 7, 8 → sync_err pulse on the second sync; output 0x08070605; no output for the partial frame.
- Missing sync at slot 0: frame 1..4, then 9 without sync → sync_err pulse, locked=0, 9 discarded.
- Backpressure: two back-to-back frames with out_ready=0 → overflow pulse at the second completion; out_data holds the second frame; out_valid clears one cycle after out_ready=1.
- Reset mid-frame: rst after two samples → all outputs 0 and HUNT; a following aligned frame is output correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types for the 1:4 TDM demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_pkg;

  localparam int NUM_LANES = 4;

  // Position of the next sample within a four-slot frame.
  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux_dec2to4.sv
// Lane write-enable decoder: one-hot enable for the lane addressed by slot.
// Latency: combinational.
// Backpressure: none.
// Ports: slot (lane index), wr_en (sample is being stored), lane_we (one-hot lane enables).
module demux_dec2to4
  import tdm_pkg::*;
(
  input  slot_t                 slot,
  input  logic                  wr_en,
  output logic [NUM_LANES-1:0]  lane_we
);

  always_comb begin
    lane_we = '0;
    if (wr_en) begin
      lane_we[slot] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux1x4.sv
// 1:4 TDM demux: aligns on in_sync, gathers four samples, emits one frame word.
// Latency: slot-3 sample at edge t -> out_valid/out_data in cycle t+1.
// Backpressure: input never stalls; an unaccepted frame is overwritten and overflow pulses.
// Ports: clk/rst (async active-high); in_data/in_valid/in_sync (sample stream);
//        out_data/out_valid/out_ready (frame word handshake); locked, sync_err, overflow (status).
module tdm_demux1x4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      in_sync,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      locked,
  output logic                      sync_err,
  output logic                      overflow
);

  state_t state_q, state_nxt;
  slot_t  slot_q, slot_nxt;
  slot_t  wr_slot;
  logic   wr_en;
  logic   sync_err_nxt;
  logic   frame_done;

  logic [NUM_LANES-1:0] lane_we;

  // Only lanes 0..2 need storage: the slot-3 sample goes straight into out_data.
  logic [NUM_LANES-2:0][WIDTH-1:0] lane_q;

  logic [NUM_LANES*WIDTH-1:0] out_data_q;
  logic                       out_valid_q;
  logic                       sync_err_q;
  logic                       overflow_q;

  // ---------------------------------------------------------------------------
  // FSM + slot counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_nxt;
      slot_q  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    slot_nxt     = slot_q;
    wr_en        = 1'b0;
    wr_slot      = slot_q;
    sync_err_nxt = 1'b0;

    case (state_q)
      HUNT: begin
        if (in_valid && in_sync) begin
          wr_en     = 1'b1;
          wr_slot   = 2'd0;
          slot_nxt  = 2'd1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (in_valid) begin
          if (in_sync && (slot_q != 2'd0)) begin
            // Early sync: abandon the partial frame and restart on this sample.
            sync_err_nxt = 1'b1;
            wr_en        = 1'b1;
            wr_slot      = 2'd0;
            slot_nxt     = 2'd1;
          end else if (!in_sync && (slot_q == 2'd0)) begin
            // Expected a frame start but none came: alignment is lost.
            sync_err_nxt = 1'b1;
            state_nxt    = HUNT;
          end else begin
            wr_en    = 1'b1;
            slot_nxt = slot_t'(slot_q + 2'd1);
          end
        end
      end
      default: begin
        state_nxt = HUNT;
        slot_nxt  = '0;
      end
    endcase
  end

  demux_dec2to4 u_dec (
    .slot    (wr_slot),
    .wr_en   (wr_en),
    .lane_we (lane_we)
  );

  // A write to the last lane is exactly a completed frame.
  assign frame_done = lane_we[NUM_LANES-1];

  // ---------------------------------------------------------------------------
  // Lane registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES-1; i++) begin
        if (lane_we[i]) begin
          lane_q[i] <= in_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output word, handshake and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_err_q <= sync_err_nxt;
      overflow_q <= 1'b0;
      if (frame_done) begin
        // A new frame wins over acceptance; it only counts as lost if the
        // held word was not taken on this same edge.
        out_data_q  <= {in_data, lane_q[2], lane_q[1], lane_q[0]};
        out_valid_q <= 1'b1;
        overflow_q  <= out_valid_q && !out_ready;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tdm_demux1x4.sv
// Testbench for tdm_demux1x4 (WIDTH=8): directed scenarios then random traffic,
// compared against a frame-level reference model built on a sample queue.
module tb_tdm_demux1x4;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sync;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic        sync_err;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_locked;
  logic [7:0]  m_part[$];
  logic        m_out_valid;
  logic [31:0] m_out_data;
  logic        m_sync_err;
  logic        m_overflow;

  tdm_demux1x4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .sync_err  (sync_err),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked    = 1'b0;
    m_part.delete();
    m_out_valid = 1'b0;
    m_out_data  = '0;
    m_sync_err  = 1'b0;
    m_overflow  = 1'b0;
  endtask

  // One clock edge of behaviour: a frame is four consecutive samples starting at a sync.
  task automatic model_edge(input logic v, input logic s, input logic [7:0] d, input logic r);
    logic        done;
    logic        err;
    logic [31:0] frame;
    done  = 1'b0;
    err   = 1'b0;
    frame = '0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_part   = '{d};
          m_locked = 1'b1;
        end
      end else if (s && m_part.size() != 0) begin
        err    = 1'b1;
        m_part = '{d};
      end else if (!s && m_part.size() == 0) begin
        err      = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          frame = {m_part[3], m_part[2], m_part[1], m_part[0]};
          done  = 1'b1;
          m_part.delete();
        end
      end
    end
    m_overflow = done && m_out_valid && !r;
    m_sync_err = err;
    if (done) begin
      m_out_data  = frame;
      m_out_valid = 1'b1;
    end else if (m_out_valid && r) begin
      m_out_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_out_valid});
    chk({tag, ".out_data"},  out_data, m_out_data);
    chk({tag, ".locked"},    {31'd0, locked},    {31'd0, m_locked});
    chk({tag, ".sync_err"},  {31'd0, sync_err},  {31'd0, m_sync_err});
    chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_overflow});
  endtask

  // Inputs are driven 1ns after an edge, applied on the next edge, outputs sampled 1ns later.
  task automatic step(input string tag, input logic v, input logic s,
                      input logic [7:0] d, input logic r);
    in_valid  = v;
    in_sync   = s;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    model_edge(v, s, d, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Aligned frame
    step("align0", 1, 1, 8'h11, 1);
    chk("align_locked_after_sync", {31'd0, locked}, 32'd1);
    step("align1", 1, 0, 8'h22, 1);
    step("align2", 1, 0, 8'h33, 1);
    step("align3", 1, 0, 8'h44, 1);
    chk("align_word", out_data, 32'h44332211);
    chk("align_valid", {31'd0, out_valid}, 32'd1);
    step("align_idle", 0, 0, 8'h00, 1);
    chk("align_valid_one_cycle", {31'd0, out_valid}, 32'd0);

    // Missing sync at slot 0 drops lock
    step("miss0", 1, 1, 8'h01, 1);
    step("miss1", 1, 0, 8'h02, 1);
    step("miss2", 1, 0, 8'h03, 1);
    step("miss3", 1, 0, 8'h04, 1);
    step("miss9", 1, 0, 8'h09, 1);
    chk("miss_sync_err", {31'd0, sync_err}, 32'd1);
    chk("miss_unlocked", {31'd0, locked}, 32'd0);

    // HUNT discard then aligned frame
    step("hunt_aa", 1, 0, 8'hAA, 1);
    step("hunt_bb", 1, 0, 8'hBB, 1);
    chk("hunt_still_unlocked", {31'd0, locked}, 32'd0);
    step("hunt0", 1, 1, 8'h01, 1);
    step("hunt_gap", 0, 0, 8'hEE, 1);
    step("hunt1", 1, 0, 8'h02, 1);
    step("hunt2", 1, 0, 8'h03, 1);
    step("hunt3", 1, 0, 8'h04, 1);
    chk("hunt_word", out_data, 32'h04030201);

    // Misplaced sync
    step("mis0", 1, 1, 8'h01, 1);
    step("mis1", 1, 0, 8'h02, 1);
    step("mis_sync", 1, 1, 8'h05, 1);
    chk("mis_sync_err", {31'd0, sync_err}, 32'd1);
    step("mis6", 1, 0, 8'h06, 1);
    chk("mis_err_one_cycle", {31'd0, sync_err}, 32'd0);
    step("mis7", 1, 0, 8'h07, 1);
    step("mis8", 1, 0, 8'h08, 1);
    chk("mis_word", out_data, 32'h08070605);

    // Backpressure: two frames without acceptance
    for (int f = 0; f < 2; f++) begin
      step("bp_s0", 1, 1, 8'h10 + 8'(f), 0);
      step("bp_s1", 1, 0, 8'h20 + 8'(f), 0);
      step("bp_s2", 1, 0, 8'h30 + 8'(f), 0);
      step("bp_s3", 1, 0, 8'h40 + 8'(f), 0);
    end
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_word", out_data, 32'h41312111);
    step("bp_hold", 0, 0, 8'h00, 0);
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    step("bp_accept", 0, 0, 8'h00, 1);
    chk("bp_cleared", {31'd0, out_valid}, 32'd0);

    // Reset mid-frame
    step("rmf0", 1, 1, 8'h55, 1);
    step("rmf1", 1, 0, 8'h66, 1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
    step("post0", 1, 1, 8'hA1, 1);
    step("post1", 1, 0, 8'hA2, 1);
    step("post2", 1, 0, 8'hA3, 1);
    step("post3", 1, 0, 8'hA4, 1);
    chk("post_word", out_data, 32'hA4A3A2A1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic       v;
      logic       s;
      logic [7:0] d;
      logic       r;
      v = ($urandom_range(0, 99) < 70);
      if (m_locked && m_part.size() == 0)
        s = ($urandom_range(0, 99) < 90);
      else
        s = ($urandom_range(0, 99) < 12);
      d = 8'($urandom);
      r = ($urandom_range(0, 99) < 60);
      step("rand", v, s, d, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
